// File: rtl/arm_bus_responder.sv
// Purpose : memory-side responder for the multicycle ARM core. It serves a word RAM
//           and an I/O page at 0x8000_0000: TXDATA (byte FIFO), STATUS/control, CYCLES counter.
// Latency : reads are combinational (0 cycles); writes are visible after the committing edge.
// Backpr. : tx_ready stalls the FIFO drain. A push into a full FIFO with no pop at the same
//           edge is dropped and sets the sticky overflow flag.
// Ports   : clk, reset (async active-low); core bus MemWrite/Adr/WriteData/ReadData;
//           tx_valid/tx_data/tx_ready byte stream out; err sticky unmapped-access flag.
module arm_bus_responder #(
   parameter int RAM_WORDS  = 64,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] Adr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        err
);
   localparam int AW = $clog2(RAM_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [29:0] TX_WORD  = 30'h2000_0000;
   localparam logic [29:0] ST_WORD  = 30'h2000_0001;
   localparam logic [29:0] CYC_WORD = 30'h2000_0002;

   // Byte lanes are not decoded; every access is a full word.
   logic unused_adr_lsb;
   assign unused_adr_lsb = ^Adr[1:0];

   logic [29:0]   word;
   logic [AW-1:0] ram_idx;
   logic          is_ram, is_tx, is_st, is_cyc, unmapped;

   assign word     = Adr[31:2];
   assign ram_idx  = Adr[AW+1:2];
   assign is_ram   = ({2'b00, word} < 32'(RAM_WORDS));
   assign is_tx    = (word == TX_WORD);
   assign is_st    = (word == ST_WORD);
   assign is_cyc   = (word == CYC_WORD);
   assign unmapped = !(is_ram || is_tx || is_st || is_cyc);

   // RAM: contents deliberately survive reset.
   logic [31:0] mem [RAM_WORDS];

   always_ff @(posedge clk) begin
      if (MemWrite && is_ram)
         mem[ram_idx] <= WriteData;
   end

   // TX FIFO
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          overflow;
   logic [31:0]   cycles;
   logic          empty, full, push, pop, push_ok;

   assign empty   = (count == '0);
   assign full    = (count == CW'(FIFO_DEPTH));
   assign push    = MemWrite && is_tx;
   assign pop     = tx_valid && tx_ready;
   // A pop at the same edge frees the slot the push needs.
   assign push_ok = push && (!full || pop);

   assign tx_valid = !empty;
   assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok)
         fifo_mem[wr_ptr] <= WriteData[7:0];
   end

   logic ovf_clr, err_clr, cyc_load;
   assign ovf_clr  = MemWrite && is_st && WriteData[0];
   assign err_clr  = MemWrite && is_st && WriteData[1];
   assign cyc_load = MemWrite && is_cyc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         err      <= 1'b0;
         cycles   <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push_ok) - CW'(pop);

         // Set events take priority over a clear in the same cycle.
         if (push && full && !pop)
            overflow <= 1'b1;
         else if (ovf_clr)
            overflow <= 1'b0;

         if (unmapped)
            err <= 1'b1;
         else if (err_clr)
            err <= 1'b0;

         cycles <= cyc_load ? WriteData : cycles + 32'd1;
      end
   end

   logic [31:0] status;
   assign status = {16'h0000, 8'(count), 4'h0, err, overflow, full, empty};

   always_comb begin
      ReadData = 32'h0;
      if (is_ram)
         ReadData = mem[ram_idx];
      else if (is_st)
         ReadData = status;
      else if (is_cyc)
         ReadData = cycles;
   end
endmodule

// File: tb/tb_arm_bus_responder.sv
// Randomized scoreboard bench for arm_bus_responder. A queue-based reference model
// predicts reads; a negedge monitor compares ReadData, the tx stream and err.
module tb_arm_bus_responder;
   localparam int RW = 64;
   localparam int FD = 8;
   localparam logic [31:0] A_TX  = 32'h8000_0000;
   localparam logic [31:0] A_ST  = 32'h8000_0004;
   localparam logic [31:0] A_CYC = 32'h8000_0008;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        MemWrite = 1'b0;
   logic [31:0] Adr = '0;
   logic [31:0] WriteData = '0;
   logic [31:0] ReadData;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b0;
   logic        err;

   arm_bus_responder #(.RAM_WORDS(RW), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .reset(reset), .MemWrite(MemWrite), .Adr(Adr),
      .WriteData(WriteData), .ReadData(ReadData), .tx_valid(tx_valid),
      .tx_data(tx_data), .tx_ready(tx_ready), .err(err)
   );

   always #5 clk = ~clk;

   // Reference model
   logic [31:0] m_mem [RW];
   logic [7:0]  mq [$];
   logic        m_ovf = 1'b0;
   logic        m_err = 1'b0;
   logic [31:0] m_cyc = '0;

   // Scoreboard
   logic [31:0] rd_q [$];
   string       nm_q [$];
   logic        rd_chk = 1'b0;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic logic is_ram_addr(input logic [31:0] a);
      return int'(a[31:2]) < RW;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      if (is_ram_addr(a)) return m_mem[int'(a[31:2])];
      if (w == A_ST)
         return {16'h0, 8'(mq.size()), 4'h0, m_err, m_ovf,
                 logic'(mq.size() == FD), logic'(mq.size() == 0)};
      if (w == A_CYC) return m_cyc;
      return 32'h0;
   endfunction

   // Effect of one rising edge on the model, from pre-edge state.
   function automatic void model_edge(input logic we, input logic [31:0] a,
                                      input logic [31:0] wd, input logic rdy);
      logic [31:0] w;
      bit was_full, do_pop, do_push, mapped;
      w        = {a[31:2], 2'b00};
      mapped   = is_ram_addr(a) || w == A_TX || w == A_ST || w == A_CYC;
      was_full = (mq.size() == FD);
      do_pop   = (mq.size() != 0) && rdy;
      do_push  = we && (w == A_TX);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
         if (!was_full || do_pop) mq.push_back(wd[7:0]);
         else m_ovf = 1'b1;
      end else if (we && w == A_ST && wd[0]) m_ovf = 1'b0;
      if (!mapped) m_err = 1'b1;
      else if (we && w == A_ST && wd[1]) m_err = 1'b0;
      m_cyc = (we && w == A_CYC) ? wd : m_cyc + 32'd1;
      if (we && is_ram_addr(a)) m_mem[int'(a[31:2])] = wd;
   endfunction

   // One bus cycle: drive, optionally queue an expected read, take the edge.
   task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic rdy, input bit chk, input bit use_k = 1'b0,
                       input logic [31:0] k = 32'h0, input string nm = "rd_data");
      MemWrite = we; Adr = a; WriteData = wd; tx_ready = rdy;
      if (chk) begin
         rd_q.push_back(use_k ? k : model_read(a));
         nm_q.push_back(nm);
         rd_chk = 1'b1;
      end
      @(posedge clk);
      model_edge(we, a, wd, rdy);
      #1;
      rd_chk = 1'b0;
   endtask

   // Monitor: compares whatever the DUT presents, away from the rising edge.
   always @(negedge clk) begin
      if (rd_chk && rd_q.size() != 0)
         check(nm_q.pop_front(), ReadData, rd_q.pop_front());
      check("tx_valid", 32'(tx_valid), 32'(mq.size() != 0));
      check("tx_data", 32'(tx_data), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
      check("err", 32'(err), 32'(m_err));
   end

   task automatic pulse_reset();
      MemWrite = 1'b0; Adr = A_ST; tx_ready = 1'b0;
      reset = 1'b0;
      #1;
      check("rst_tx_valid", 32'(tx_valid), 32'h0);
      check("rst_tx_data", 32'(tx_data), 32'h0);
      check("rst_status", ReadData, 32'h0000_0001);
      mq.delete();
      m_ovf = 1'b0; m_err = 1'b0; m_cyc = '0;
      #1 reset = 1'b1;
      #1;
   endtask

   initial begin
      logic [31:0] a, d;
      int op;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      // Give every RAM word a defined value.
      for (int i = 0; i < RW; i++) step(1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0);

      // RAM write then reads, including an unaligned byte address
      step(1'b1, 32'h10, 32'h1234_5678, 1'b0, 1'b0);
      step(1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 32'h1234_5678, "ram_rd");
      step(1'b0, 32'h13, 32'h0, 1'b0, 1'b1, 1'b1, 32'h1234_5678, "ram_rd_lsb");
      step(1'b0, A_ST, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0001, "status_idle");

      // Fill, overflow, clear
      for (int i = 1; i <= 8; i++) step(1'b1, A_TX, 32'(i), 1'b0, 1'b0);
      step(1'b0, A_ST, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0802, "status_full");
      step(1'b1, A_TX, 32'h9, 1'b0, 1'b0);
      step(1'b0, A_ST, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0806, "status_ovf");
      step(1'b1, A_ST, 32'h1, 1'b0, 1'b0);
      step(1'b0, A_ST, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0802, "ovf_clear");

      // Push into full FIFO with a simultaneous pop, then drain
      step(1'b1, A_TX, 32'hAA, 1'b1, 1'b0);
      step(1'b0, A_ST, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0802, "full_push_pop");
      for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step(1'b0, A_ST, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0001, "drained");

      // Counter load and wrap
      step(1'b1, A_CYC, 32'hFFFF_FFFE, 1'b0, 1'b0);
      step(1'b0, A_CYC, 32'h0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, "cyc_load");
      step(1'b0, A_CYC, 32'h0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, "cyc_inc");
      step(1'b0, A_CYC, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0000, "cyc_wrap");

      // Unmapped access and err clear
      step(1'b0, 32'h4000_0000, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, "unmapped_rd");
      step(1'b0, A_ST, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0009, "status_err");
      step(1'b1, A_ST, 32'h2, 1'b0, 1'b0);
      step(1'b0, A_ST, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0001, "err_clear");

      // Asynchronous reset with pending bytes
      for (int i = 0; i < 3; i++) step(1'b1, A_TX, 32'(8'hC0 + i), 1'b0, 1'b0);
      pulse_reset();
      step(1'b0, A_CYC, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, "cyc_after_rst");

      // Randomized traffic checked against the model
      for (int n = 0; n < 2000; n++) begin
         op = int'($urandom_range(0, 9));
         d  = $urandom;
         a  = 32'($urandom_range(0, RW - 1) * 4 + $urandom_range(0, 3));
         case (op)
            0, 1: step(1'b1, a, d, $urandom_range(0, 2) == 0, 1'b1);
            2, 3: step(1'b0, a, d, $urandom_range(0, 2) == 0, 1'b1);
            4, 5: step(1'b1, A_TX | 32'($urandom_range(0, 3)), d, $urandom_range(0, 2) == 0, 1'b1);
            6:    step($urandom_range(0, 1) == 0, A_ST, d, $urandom_range(0, 2) == 0, 1'b1);
            7:    step(1'b0, ($urandom_range(0, 1) == 0) ? A_ST : A_TX, d, 1'b1, 1'b1);
            8:    step($urandom_range(0, 3) == 0, A_CYC, d, $urandom_range(0, 2) == 0, 1'b1);
            default: begin
               case ($urandom_range(0, 3))
                  0: a = 32'h0000_0100 + 32'($urandom_range(0, 255));
                  1: a = 32'h8000_000C;
                  2: a = 32'h4000_0000;
                  default: a = 32'hFFFF_FFFC;
               endcase
               if ($urandom_range(0, 3) == 0) step($urandom_range(0, 1) == 0, a, d, 1'b1, 1'b1);
               else step(1'b0, A_ST, d, 1'b1, 1'b1);
            end
         endcase
      end

      check("rd_queue_drained", 32'(rd_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/arm_bus_responder.md
# arm_bus_responder

Memory-side responder for the multicycle ARM core's single-port bus (MemWrite, Adr, WriteData, ReadData). It serves a word-addressed RAM for instructions and data, plus a small memory-mapped I/O page. The page holds a byte transmit FIFO drained through a valid/ready port, a status/control register and a free-running cycle counter. It sits beside the core at top level and replaces a plain memory model.

## Interface
- RAM_WORDS, 64: RAM depth in 32-bit words; power of 2, at most 2^20.
- FIFO_DEPTH, 8: TX FIFO depth in bytes; power of 2, 2..128.
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- MemWrite  input  1  write strobe from the core; the write is committed at the rising edge.
- Adr  input  32  byte address from the core; Adr[1:0] is ignored everywhere.
- WriteData  input  32  write data from the core.
- ReadData  output  32  read data; combinational from Adr and current state.
- tx_valid  output  1  the FIFO head byte is available.
- tx_data  output  8  FIFO head byte; 0 when the FIFO is empty.
- tx_ready  input  1  downstream accepts the head byte.
- err  output  1  sticky flag: an unmapped address was accessed.

## Operation
Address map, decoded on the word address Adr[31:2]:
- RAM: Adr < RAM_WORDS*4. Index is Adr[log2(RAM_WORDS)+1:2].
  - Read returns the word.
  - Write stores WriteData.
- TXDATA, 0x8000_0000:
  - Write pushes WriteData[7:0] into the FIFO.
  - Read returns 0.
- STATUS, 0x8000_0004. Read returns:
  - [0] empty, [1] full, [2] overflow (sticky), [3] err (sticky).
  - [15:8] FIFO count, zero-extended. All other bits are 0.
- STATUS writes: WriteData[0]=1 clears overflow; WriteData[1]=1 clears err. Other bits are ignored.
- CYCLES, 0x8000_0008:
  - Read returns the 32-bit counter.
  - Write loads the counter with WriteData.
- Any other address: read returns 0. Every access to an unmapped address, read or write, sets err at the next edge. A read counts as an access whenever Adr holds that address at an edge.
- FIFO: circular buffer with read and write pointers and a count of width log2(FIFO_DEPTH)+1.
  - Push: MemWrite && Adr==TXDATA.
  - Pop: tx_valid && tx_ready.
  - tx_valid = (count != 0). tx_data = buffer[rd_ptr] when non-empty.
- Cycle counter: increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0.

## Timing
- Reset values while reset=0:
  - tx_valid=0, tx_data=0, err=0.
  - FIFO empty (pointers 0, count 0), overflow=0, counter=0.
  - ReadData follows the decode using that reset state.
  - RAM contents are not reset.
- Reads have zero latency: ReadData is valid in the same cycle that Adr is stable. The core has no stall input.
- Writes become visible one cycle later, to reads after the committing edge.
- FIFO boundary rules:
  - Push when not full: accepted; count+1.
  - Push when full with no pop at the same edge: byte dropped, overflow set, pointers unchanged.
  - Push when full with a pop at the same edge: both happen; count stays FIFO_DEPTH.
  - Push and pop when neither empty nor full: count unchanged.
  - Pop when empty: impossible, because tx_valid=0.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky-flag priority: a clear written in the same cycle as a new set event leaves the flag set.
- Counter priority: a CYCLES write wins over the increment; the counter holds WriteData after the edge and increments from the next edge.
- Reset asserted mid-operation: immediate asynchronous return to reset values. Pending FIFO bytes are discarded and tx_valid drops without waiting for clk.
- tx_valid/tx_data change only on clk edges or reset. Once asserted, tx_valid holds with tx_data stable until popped.

## Test plan
- Reset, then write 0x1234_5678 to RAM address 0x10, read 0x10 and 0x13 -> both read 0x1234_5678. STATUS reads 0x0000_0001; err=0.
- With tx_ready=0, push bytes 0x01..0x09 with FIFO_DEPTH=8:
  - After the 8th push: STATUS=0x0000_0802, tx_data=0x01.
  - The 9th push sets overflow: STATUS=0x0000_0806.
  - Write STATUS=1 -> STATUS=0x0000_0802.
- With a full FIFO, push 0xAA in the same cycle tx_ready=1 pops 0x01 -> no overflow, count stays 8. Draining yields 0x02..0x08 then 0xAA.
- Write CYCLES=0xFFFF_FFFE, then read on the following cycles -> 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- Read address 0x4000_0000 -> ReadData=0; err=1 after the edge; STATUS bit 3 set. Write STATUS=2 -> err=0.
- Push 3 bytes, then pulse reset low between edges -> tx_valid=0, tx_data=0 and STATUS=0x0000_0001 immediately. Counter reads 0 after release.
